// File: rtl/nvdla_sdp_rdma_cq_gen2.sv
// -----------------------------------------------------------------------------
// nvdla_sdp_rdma_cq_gen2
//
// Context queue between the SDP RDMA request generator (ig) and the
// return-data egress (eg). Single clock, flop-array storage, any depth
// 2..255 (non-power-of-2 depths wrap explicitly at DEPTH-1).
//
// Ports:
//   nvdla_core_clk_mgated  gated core clock, all flops on posedge
//   nvdla_core_rstn        asynchronous active-low reset
//   ig2cq_pvld/prdy/pd     write handshake and payload
//   cq2eg_pvld/prdy/pd     read handshake and head-entry payload
//   cfg_wr_limit           soft capacity (0 or >DEPTH selects DEPTH)
//   cfg_afull_thresh       almost-full threshold (0 disables)
//   cfg_flush              single-cycle synchronous clear
//   hwm_clr                reload high-water mark with next occupancy
//   cq_count               registered occupancy
//   cq_afull               registered almost-full flag
//   cq_hwm                 maximum occupancy since reset/clear/flush
//   cq_idle                queue empty and no write request this cycle
// -----------------------------------------------------------------------------
module nvdla_sdp_rdma_cq_gen2 #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 160,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             nvdla_core_clk_mgated,
   input  logic             nvdla_core_rstn,
   input  logic             ig2cq_pvld,
   output logic             ig2cq_prdy,
   input  logic [WIDTH-1:0] ig2cq_pd,
   output logic             cq2eg_pvld,
   input  logic             cq2eg_prdy,
   output logic [WIDTH-1:0] cq2eg_pd,
   input  logic [CW-1:0]    cfg_wr_limit,
   input  logic [CW-1:0]    cfg_afull_thresh,
   input  logic             cfg_flush,
   input  logic             hwm_clr,
   output logic [CW-1:0]    cq_count,
   output logic             cq_afull,
   output logic [CW-1:0]    cq_hwm,
   output logic             cq_idle
);

   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [AW-1:0] LAST_ADR  = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_adr_r;
   logic [AW-1:0]    rd_adr_r;
   logic [CW-1:0]    count_r;
   logic             busy_r;
   logic             afull_r;
   logic [CW-1:0]    hwm_r;

   logic             push_s;
   logic             pop_s;
   logic [CW-1:0]    count_next_s;
   logic [CW-1:0]    eff_limit_s;
   logic [AW-1:0]    wr_adr_inc_s;
   logic [AW-1:0]    rd_adr_inc_s;

   // Handshake qualification; flush blocks both sides for its cycle.
   always_comb begin
      ig2cq_prdy = ~busy_r & ~cfg_flush;
      cq2eg_pvld = (count_r != {CW{1'b0}}) & ~cfg_flush;
      push_s     = ig2cq_pvld & ig2cq_prdy;
      pop_s      = cq2eg_pvld & cq2eg_prdy;
      cq2eg_pd   = mem_r[rd_adr_r];
      cq_count   = count_r;
      cq_afull   = afull_r;
      cq_hwm     = hwm_r;
      cq_idle    = (count_r == {CW{1'b0}}) & ~ig2cq_pvld;
   end

   // Next occupancy, effective write limit and wrapped pointer increments.
   always_comb begin
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CW'(1);
         2'b01:   count_next_s = count_r - CW'(1);
         default: count_next_s = count_r;
      endcase

      eff_limit_s = cfg_wr_limit;
      if ((cfg_wr_limit == {CW{1'b0}}) || (cfg_wr_limit > DEPTH_C)) begin
         eff_limit_s = DEPTH_C;
      end else begin
         eff_limit_s = cfg_wr_limit;
      end

      // Explicit wrap so non-power-of-2 depths never address past the array.
      wr_adr_inc_s = wr_adr_r + AW'(1);
      if (wr_adr_r == LAST_ADR) begin
         wr_adr_inc_s = {AW{1'b0}};
      end else begin
         wr_adr_inc_s = wr_adr_r + AW'(1);
      end

      rd_adr_inc_s = rd_adr_r + AW'(1);
      if (rd_adr_r == LAST_ADR) begin
         rd_adr_inc_s = {AW{1'b0}};
      end else begin
         rd_adr_inc_s = rd_adr_r + AW'(1);
      end
   end

   // Payload storage; not reset, contents are don't-care until written.
   always_ff @(posedge nvdla_core_clk_mgated) begin
      if (push_s) begin
         mem_r[wr_adr_r] <= ig2cq_pd;
      end
   end

   // Pointers, occupancy, ready throttle, almost-full and high-water mark.
   always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         wr_adr_r <= {AW{1'b0}};
         rd_adr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         busy_r   <= 1'b0;
         afull_r  <= 1'b0;
         hwm_r    <= {CW{1'b0}};
      end else if (cfg_flush) begin
         wr_adr_r <= {AW{1'b0}};
         rd_adr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         busy_r   <= 1'b0;
         afull_r  <= 1'b0;
         hwm_r    <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_adr_r <= wr_adr_inc_s;
         end
         if (pop_s) begin
            rd_adr_r <= rd_adr_inc_s;
         end
         count_r <= count_next_s;
         // eff_limit never exceeds DEPTH, so a full queue always reads busy.
         busy_r  <= (count_next_s >= eff_limit_s);
         afull_r <= (cfg_afull_thresh != {CW{1'b0}}) &
                    (count_next_s >= cfg_afull_thresh);
         // Clear reloads the live occupancy so the mark stays meaningful.
         if (hwm_clr) begin
            hwm_r <= count_next_s;
         end else if (count_next_s > hwm_r) begin
            hwm_r <= count_next_s;
         end
      end
   end

endmodule

// File: doc/nvdla_sdp_rdma_cq_gen2.md
Name: nvdla_sdp_rdma_cq_gen2

Overview:
- Parametrised, synchronous, single-clock context queue for SDP read-DMA ingress-to-egress command tracking.
- Successor to the fixed 160x16 queue. Adds:
  - parametrised width and depth, including non-power-of-2 depths
  - runtime write limit
  - synchronous flush
  - occupancy, almost-full and high-water-mark status
- Sits between the RDMA request generator (ig) and the return-data egress (eg).

Parameters:
- WIDTH, 16, payload width in bits.
- DEPTH, 160, entry count; any value 2..255.
- AW, $clog2(DEPTH), address width (derived; do not override).
- CW, $clog2(DEPTH+1), count width (derived; do not override).

Ports:
- nvdla_core_clk_mgated  input  1  gated core clock; all flops on posedge.
- nvdla_core_rstn  input  1  asynchronous active-low reset.
- ig2cq_pvld  input  1  write valid.
- ig2cq_prdy  output  1  write ready.
- ig2cq_pd  input  WIDTH  write payload.
- cq2eg_pvld  output  1  read valid.
- cq2eg_prdy  input  1  read ready.
- cq2eg_pd  output  WIDTH  read payload (head entry).
- cfg_wr_limit  input  CW  soft capacity; 0 or >DEPTH means DEPTH.
- cfg_afull_thresh  input  CW  almost-full threshold; 0 disables.
- cfg_flush  input  1  synchronous single-cycle clear pulse.
- hwm_clr  input  1  clears the high-water mark.
- cq_count  output  CW  current occupancy.
- cq_afull  output  1  registered almost-full.
- cq_hwm  output  CW  maximum occupancy since reset/clear/flush.
- cq_idle  output  1  queue empty and no handshake this cycle.

Behaviour:
- Reset (nvdla_core_rstn low, asynchronous):
  - wr_adr=0, rd_adr=0, count=0, busy=0, afull=0, hwm=0.
  - Outputs: ig2cq_prdy=1, cq2eg_pvld=0, cq_count=0, cq_afull=0, cq_hwm=0, cq_idle=1.
  - Storage array is not reset; cq2eg_pd is don't-care while cq2eg_pvld=0.
- Handshakes:
  - push = ig2cq_pvld & ig2cq_prdy; pop = cq2eg_pvld & cq2eg_prdy.
  - ig2cq_prdy = !busy & !cfg_flush.
  - cq2eg_pvld = (count!=0) & !cfg_flush.
- Data path:
  - Storage is a DEPTH x WIDTH flop array.
  - push writes ig2cq_pd to mem[wr_adr].
  - cq2eg_pd = mem[rd_adr], combinational mux.
  - Latency: push in cycle N gives cq2eg_pvld=1 with that data in N+1 when the queue was empty.
  - Data is held stable while cq2eg_pvld & !cq2eg_prdy.
- Pointers:
  - Each pointer increments on its own event.
  - Wrap rule: DEPTH-1 -> 0 (explicit compare, not modulo-2^AW).
- Count:
  - count_next = count + push - pop.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Count never exceeds DEPTH and never underflows.
- Busy (registered):
  - eff_limit = (cfg_wr_limit==0 || cfg_wr_limit>DEPTH) ? DEPTH : cfg_wr_limit.
  - busy <= (count_next >= eff_limit).
  - Lowering cfg_wr_limit below the current count holds ready low until the queue drains below the new limit; stored entries are not lost.
- Full: count==DEPTH forces busy=1. Pop at full gives ready=1 next cycle.
- Empty: a pop is impossible when count==0 because cq2eg_pvld is 0.
- Flush (cfg_flush=1):
  - In the flush cycle, ready and valid are forced 0, so no handshakes occur.
  - Next cycle: wr_adr=rd_adr=count=0, busy=0, afull=0, hwm=0.
  - A flush asserted while in-flight data is present discards all entries.
- cq_afull <= (cfg_afull_thresh!=0) & (count_next >= cfg_afull_thresh).
- High-water mark:
  - hwm <= max(hwm, count_next).
  - hwm_clr loads count_next (not 0).
  - cfg_flush overrides hwm_clr.
- cq_count = count (registered).
- cq_idle = (count==0) & !ig2cq_pvld.

Test Plan:
1. Reset then single push of 0xA5A5 -> next cycle cq2eg_pvld=1, cq2eg_pd=0xA5A5, cq_count=1; pop -> cq2eg_pvld=0, cq_count=0.
2. DEPTH=160, push 160 with cq2eg_prdy=0 -> ig2cq_prdy=0 after the 160th accept, cq_count=160, cq_hwm=160; drain all -> data in order 0..159, pointers wrap 159->0; push 10 more -> correct data.
3. Continuous push+pop at count=5 for 300 cycles -> cq_count stays 5, no stall, FIFO order preserved across wraps.
4. cfg_wr_limit=8, cfg_afull_thresh=6 -> cq_afull=1 after the 6th push, ig2cq_prdy=0 after the 8th; set cfg_wr_limit=4 with count=8 -> prdy stays 0 until count drops to 3.
5. Fill to 20, pulse cfg_flush together with ig2cq_pvld=1 and cq2eg_prdy=1 -> no handshake in that cycle; next cycle cq_count=0, cq2eg_pvld=0, cq_hwm=0, ig2cq_prdy=1.
6. Assert nvdla_core_rstn low mid-traffic at count=37 -> all outputs return to reset values immediately; the first push after release is read back correctly.
